// File: rtl/orao_tape_player.sv
// Purpose: streams a downloaded 8-bit unsigned PCM WAV through a small FIFO and
//          digitises each sample with a hysteresis comparator into a tape level.
// Latency: a byte popped on a sample tick is reflected on tape_out the next cycle;
//          ioctl_wait is raised (registered) once the FIFO holds DEPTH-2 bytes.
// Ports:   clk_sys/reset_n clock and async active-low reset; play_en run/pause;
//          ioctl_download/wr/addr/dout host byte stream, ioctl_wait backpressure;
//          tape_out digitised level; active busy; underrun pulse; overflow sticky.
module orao_tape_player #(
  parameter int         DIV       = 1134,
  parameter int         DEPTH     = 16,
  parameter int         HDR_BYTES = 44,
  parameter int         PREFILL   = DEPTH / 2,
  parameter logic [7:0] THRESH    = 8'h80,
  parameter logic [7:0] HYST      = 8'h10
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        play_en,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        tape_out,
  output logic        active,
  output logic        underrun,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  // Comparator bounds are formed in 9 bits so that carry/borrow can be
  // detected and clamped to the byte range.
  localparam logic [8:0] SUM9  = {1'b0, THRESH} + {1'b0, HYST};
  localparam logic [8:0] DIFF9 = {1'b0, THRESH} - {1'b0, HYST};
  localparam logic [7:0] HI_B  = SUM9[8]  ? 8'hFF : SUM9[7:0];
  localparam logic [7:0] LO_B  = DIFF9[8] ? 8'h00 : DIFF9[7:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PLAY,
    S_DRAIN
  } state_t;

  state_t          state;
  logic            dl_q;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [DW-1:0]   div_cnt;

  logic            dl_rise;
  logic            dl_fall;
  logic            running;
  logic            tick;
  logic            empty;
  logic            full;
  logic            wr_data;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      rd_byte;

  always_comb begin
    dl_rise = ioctl_download & ~dl_q;
    dl_fall = ~ioctl_download & dl_q;
    running = ((state == S_PLAY) || (state == S_DRAIN)) && play_en;
    tick    = running && (div_cnt == DW'(DIV - 1));
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    // Only data bytes of an ongoing download are candidates; a rising edge
    // already counts as ongoing since the flush happens on that same cycle.
    wr_data = ioctl_wr && ioctl_download && (ioctl_addr >= 25'(HDR_BYTES)) &&
              ((state != S_IDLE) || dl_rise);
    // After a flush the FIFO is empty, so a byte arriving with the edge fits.
    push    = wr_data && (dl_rise || !full);
    pop     = tick && !empty && !dl_rise;
    if (dl_rise) begin
      count_nxt = CW'(push);
      wr_addr   = '0;
    end else begin
      count_nxt = count + CW'(push) - CW'(pop);
      wr_addr   = wr_ptr;
    end
    rd_byte = mem[rd_ptr];
  end

  assign active = (state != S_IDLE);

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_addr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      // Held high so a download still asserted when reset releases is not
      // mistaken for a fresh start; the host must drop and re-raise it.
      dl_q       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      div_cnt    <= '0;
      tape_out   <= 1'b0;
      ioctl_wait <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      count      <= count_nxt;
      underrun   <= tick && empty && (state == S_PLAY) && !dl_rise;
      ioctl_wait <= ((state != S_IDLE) || dl_rise) && (count_nxt >= CW'(DEPTH - 2));

      if (state == S_IDLE) begin
        tape_out <= 1'b0;
      end else if (pop) begin
        if (rd_byte >= HI_B) begin
          tape_out <= 1'b1;
        end else if (rd_byte < LO_B) begin
          tape_out <= 1'b0;
        end
      end

      if (running) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      end

      if (dl_rise) begin
        // A new download restarts from scratch regardless of current state.
        state    <= S_FILL;
        wr_ptr   <= push ? AW'(1) : '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
        div_cnt  <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        if (wr_data && full) begin
          overflow <= 1'b1;
        end
        case (state)
          S_IDLE: ;
          S_FILL: begin
            if (dl_fall) begin
              state   <= empty ? S_IDLE : S_PLAY;
              div_cnt <= '0;
            end else if (count >= CW'(PREFILL)) begin
              state   <= S_PLAY;
              div_cnt <= '0;
            end
          end
          // Level-sensitive so that a PLAY entered by the falling edge itself
          // (short file) still proceeds to drain.
          S_PLAY: begin
            if (!ioctl_download) begin
              state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (tick && empty) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_orao_tape_player.sv
module tb_orao_tape_player;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int HDR   = 4;
  localparam int PREF  = 4;
  localparam int THR   = 'h80;
  localparam int HYS   = 'h10;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        play_en = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, tape_out, active, underrun, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int ucnt  = 0;

  logic [7:0] bb [16];
  logic       be [16];

  typedef struct {
    logic [7:0] b;
    logic       exp;
    int         grp;
  } vec_t;
  vec_t tbl [13];

  orao_tape_player #(
    .DIV(DIV), .DEPTH(DEPTH), .HDR_BYTES(HDR), .PREFILL(PREF),
    .THRESH(8'h80), .HYST(8'h10)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .play_en(play_en),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .tape_out(tape_out), .active(active),
    .underrun(underrun), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (underrun === 1'b1) ucnt <= ucnt + 1;

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hysteresis reference: thresholds from the centre/half-band clamped to 0..255.
  function automatic void model(input int n, input logic start);
    int   hi = (THR + HYS > 255) ? 255 : THR + HYS;
    int   lo = (THR - HYS < 0) ? 0 : THR - HYS;
    logic t  = start;
    for (int i = 0; i < n; i++) begin
      if (int'(bb[i]) >= hi) t = 1'b1;
      else if (int'(bb[i]) < lo) t = 1'b0;
      be[i] = t;
    end
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic load(input int k);
    int cnt;
    ioctl_download = 1'b1;
    step();
    chk("rise_ovf_clear", overflow, 0);
    chk("rise_active", active, 1);
    for (int a = 0; a < HDR; a++) wr(a, 8'($urandom));
    for (int j = 0; j < k; j++) begin
      wr(HDR + j, bb[j]);
      cnt = (j + 1 > DEPTH) ? DEPTH : j + 1;
      chk($sformatf("wait_after_%0d", j + 1), ioctl_wait, 32'(cnt >= DEPTH - 2));
      chk($sformatf("ovf_after_%0d", j + 1), overflow, 32'(j + 1 > DEPTH));
    end
  endtask

  task automatic drain(input int n);
    ioctl_download = 1'b0;
    repeat (3) step();
    chk("drain_active", active, 1);
    play_en = 1'b1;
    for (int j = 0; j < n; j++) begin
      repeat (DIV) @(posedge clk_sys);
      @(negedge clk_sys);
      chk($sformatf("tape[%0d]", j), tape_out, be[j]);
      chk("drain_no_underrun", underrun, 0);
    end
    repeat (DIV) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("idle_active", active, 0);
    chk("idle_hold", tape_out, be[n-1]);
    chk("idle_wait", ioctl_wait, 0);
    @(negedge clk_sys);
    chk("idle_tape0", tape_out, 0);
    play_en = 1'b0;
  endtask

  task automatic run_burst(input int k);
    load(k);
    drain((k > DEPTH) ? DEPTH : k);
  endtask

  initial begin
    int k;
    int u0;
    bit done;
    logic exp4 [4];

    tbl[0]  = '{8'h95, 1'b1, 0};
    tbl[1]  = '{8'h85, 1'b1, 0};
    tbl[2]  = '{8'h75, 1'b1, 0};
    tbl[3]  = '{8'h6F, 1'b0, 0};
    tbl[4]  = '{8'h85, 1'b0, 0};
    tbl[5]  = '{8'h8F, 1'b0, 1};
    tbl[6]  = '{8'h90, 1'b1, 1};
    tbl[7]  = '{8'h70, 1'b1, 1};
    tbl[8]  = '{8'h6F, 1'b0, 1};
    tbl[9]  = '{8'h70, 1'b0, 1};
    tbl[10] = '{8'h00, 1'b0, 1};
    tbl[11] = '{8'h8F, 1'b0, 1};
    tbl[12] = '{8'hFF, 1'b1, 1};

    // Reset state
    #3;
    chk("rst_tape", tape_out, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_active", active, 0);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    step();

    // Table-driven comparator bursts
    for (int g = 0; g < 2; g++) begin
      k = 0;
      for (int i = 0; i < 13; i++) begin
        if (tbl[i].grp == g) begin
          bb[k] = tbl[i].b;
          be[k] = tbl[i].exp;
          k++;
        end
      end
      run_burst(k);
    end

    // Header skip with live playback: PLAY starts right after the 4th data byte
    u0 = ucnt;
    play_en = 1'b1;
    ioctl_download = 1'b1;
    step();
    for (int a = 0; a < HDR; a++) wr(a, 8'hFF);
    wr(4, 8'hF0); wr(5, 8'hF0); wr(6, 8'h10); wr(7, 8'h10);
    repeat (DIV) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("hs_before_pop", tape_out, 0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("hs_tape0", tape_out, 1);
    exp4 = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int j = 1; j < 4; j++) begin
      repeat (DIV) @(posedge clk_sys);
      @(negedge clk_sys);
      chk($sformatf("hs_tape%0d", j), tape_out, exp4[j]);
    end
    ioctl_download = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk_sys);
      if (active == 1'b0) done = 1'b1;
    end
    chk("hs_drain_idle", active, 0);
    chk("hs_no_underrun", ucnt - u0, 0);
    play_en = 1'b0;
    step();

    // Header only then fall: FILL -> IDLE
    load(0);
    ioctl_download = 1'b0;
    repeat (3) step();
    chk("empty_fall_idle", active, 0);

    // Backpressure and overflow: 9th byte dropped, 8 pops only
    for (int i = 0; i < 9; i++) bb[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    model(8, 1'b0);
    run_burst(9);
    chk("ovf_sticky", overflow, 1);

    // Restart in DRAIN with 3 bytes still queued
    load(9);
    ioctl_download = 1'b0;
    repeat (3) step();
    play_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      repeat (DIV) @(posedge clk_sys);
      @(negedge clk_sys);
      chk($sformatf("pre_restart_tape[%0d]", j), tape_out, be[j]);
    end
    play_en = 1'b0;
    step();
    chk("pre_restart_ovf", overflow, 1);
    chk("pre_restart_active", active, 1);
    bb[0] = 8'h80; bb[1] = 8'h80;
    be[0] = 1'b1;  be[1] = 1'b1;
    run_burst(2);

    // Underrun: 4 bytes, download kept high, no further writes
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h95; bb[3] = 8'h85;
    exp4 = '{1'b0, 1'b1, 1'b1, 1'b1};
    load(4);
    step();
    u0 = ucnt;
    play_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      repeat (DIV) @(posedge clk_sys);
      @(negedge clk_sys);
      chk($sformatf("ur_tape[%0d]", j), tape_out, exp4[j]);
      chk("ur_none_yet", underrun, 0);
    end
    for (int m = 1; m <= 3; m++) begin
      repeat (DIV) @(posedge clk_sys);
      @(negedge clk_sys);
      chk($sformatf("ur_pulse%0d", m), underrun, 1);
      chk($sformatf("ur_hold%0d", m), tape_out, 1);
      chk($sformatf("ur_count%0d", m), ucnt - u0, m - 1);
    end
    play_en = 1'b0;
    wr(8, 8'hFF);
    wr(9, 8'hFF);

    // Reset mid-PLAY with two stale bytes queued
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tape", tape_out, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_overflow", overflow, 0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) step();
    chk("post_rst_idle", active, 0);
    ioctl_download = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      bb[i] = 8'h00;
      be[i] = 1'b0;
    end
    run_burst(3);

    // Randomized bursts against the reference model
    for (int t = 0; t < 20; t++) begin
      k = $urandom_range(1, 10);
      for (int i = 0; i < k; i++) bb[i] = 8'($urandom);
      model((k > DEPTH) ? DEPTH : k, 1'b0);
      run_burst(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/orao_tape_player.md
ORAO_TAPE_PLAYER -- requirements
Module: orao_tape_player

Interface
REQ-001 Parameter DIV, default 1134, clk_sys cycles per sample tick (50 MHz / 44.1 kHz); SHALL be >= 2.
REQ-002 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two >= 4.
REQ-003 Parameter HDR_BYTES, default 44, number of leading WAV header bytes discarded.
REQ-004 Parameter PREFILL, default DEPTH/2, FIFO count that starts playback.
REQ-005 Parameter THRESH, default 8'h80, and parameter HYST, default 8'h10, set the unsigned comparator centre and half-band.
REQ-006 Ports:
- clk_sys  in  1  system clock, sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- play_en  in  1  1 = run; 0 = pause.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  unsigned PCM byte.
- ioctl_wait  out  1  backpressure to host.
- tape_out  out  1  digitised tape level.
- active  out  1  high in FILL, PLAY or DRAIN.
- underrun  out  1  one-cycle pulse.
- overflow  out  1  sticky error flag.

Function
REQ-007 States SHALL be IDLE, FILL, PLAY and DRAIN; active SHALL equal (state != IDLE).
REQ-008 The block SHALL detect the ioctl_download rising edge from a registered copy; in any state this edge SHALL flush the FIFO, clear overflow and enter FILL.
REQ-009 On ioctl_wr with ioctl_addr < HDR_BYTES, the byte SHALL be discarded; otherwise it SHALL be pushed if the FIFO is not full.
REQ-010 A push while the FIFO is full SHALL drop the byte and set overflow until the next download rising edge or reset.
REQ-011 ioctl_wait SHALL be registered and high whenever the FIFO count >= DEPTH-2; it SHALL be low in IDLE.
REQ-012 Count width SHALL be log2(DEPTH)+1 bits; pointers SHALL wrap modulo DEPTH.
REQ-013 FILL -> PLAY SHALL occur when count >= PREFILL or when download falls; a fall with an empty FIFO SHALL go FILL -> IDLE.
REQ-014 PLAY -> DRAIN SHALL occur on the download falling edge; DRAIN -> IDLE SHALL occur on a tick with an empty FIFO.
REQ-015 The tick divider SHALL count 0..DIV-1 and emit a one-cycle tick on DIV-1, only in PLAY or DRAIN with play_en=1.
REQ-016 The divider SHALL hold its value while play_en=0 and SHALL reset to 0 on entry to PLAY.
REQ-017 On a tick with the FIFO non-empty, the block SHALL pop one byte b.
REQ-018 tape_out SHALL be updated the cycle after the pop:
- 1 if b >= THRESH+HYST;
- 0 if b < THRESH-HYST;
- otherwise it SHALL hold.
REQ-019 Comparator bounds SHALL be computed in 9 bits and saturated to 0..255.
REQ-020 On a tick with the FIFO empty in PLAY, the block SHALL pulse underrun for one cycle, hold tape_out and stay in PLAY.
REQ-021 A simultaneous push and pop SHALL leave the count unchanged; a push to an empty FIFO SHALL be poppable no earlier than the next cycle.
REQ-022 In IDLE, tape_out SHALL return to 0 one cycle after entry.

Reset
REQ-023 reset_n=0 SHALL asynchronously force:
- state IDLE and FIFO empty;
- divider 0;
- tape_out, ioctl_wait, underrun, overflow and active all 0.
REQ-024 Reset mid-download SHALL abandon data; after release the block SHALL wait in IDLE for a new download rising edge.

Verification (DIV=4, DEPTH=8, HDR_BYTES=4, PREFILL=4, THRESH=80h, HYST=10h)
REQ-025 Header skip: download addrs 0..3 then 4..7 = F0,F0,10,10, then fall.
- Required: FILL -> PLAY after addr 7.
- tape_out sequence 1,1,0,0 at 4-cycle spacing.
- Then DRAIN -> IDLE, active=0.
REQ-026 Hysteresis: bytes 95,85,75,6F,85 yield tape_out 1,1,1,0,0.
REQ-027 Backpressure: 8 data bytes written with no ticks (play_en=0).
- Required: ioctl_wait=1 once count=6.
- A forced 9th write sets overflow=1 and the count stays 8.
REQ-028 Underrun: PLAY with 4 bytes and the download held high with no writes.
- Required: underrun pulses once per tick after the 4th pop.
- tape_out holds its last value.
REQ-029 Reset mid-PLAY: reset_n low for 1 cycle.
- Required: all outputs 0 immediately.
- New download rising edge re-enters FILL with count 0.
REQ-030 Restart in DRAIN: download rising edge with 3 bytes queued.
- Required: FIFO flushed and state FILL.
- overflow cleared and no stale byte played.
